load_unit: RTL and testbench



---
 rtl/load_pkg.sv | 44 ++++
 rtl/load_extend.sv | 44 ++++
 rtl/load_unit.sv | 183 ++++++++++++++++++
 tb/tb_load_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_pkg
// Purpose  : Shared definitions for the RV32I load path: load funct3
//            encodings, the load FSM state type and alignment/legality
//            helpers used by the unit and the writeback bypass.
// Revision : 1.0 - initial release
// ============================================================================
package load_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } load_state_t;

  // Encodings 011, 110 and 111 are not loads in RV32I.
  function automatic logic is_illegal(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_illegal = 1'b0;
      default:                             is_illegal = 1'b1;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] lane);
    case (funct3)
      F3_LH, F3_LHU: is_misaligned = lane[0];
      F3_LW:         is_misaligned = |lane;
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage : load_pkg
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Combinational byte/halfword/word extraction and sign/zero
//            extension of a 32-bit memory word for RV32I loads.
// Ports    : word   in  32  raw memory word
//            lane   in   2  byte offset within the word (addr[1:0])
//            funct3 in   3  load funct3 (LB/LH/LW/LBU/LHU)
//            result out 32  extended load result (0 for illegal funct3)
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      F3_LW:   result = word;
      default: result = 32'd0;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_unit
// Purpose  : Read-side data-memory port for the RV32I core. Accepts one load
//            at a time, issues a single word-aligned read, extracts and
//            extends the result and returns it over a valid/ready handshake.
//            Misaligned addresses, illegal funct3 and memory timeouts are
//            returned as error responses with zero data.
// Ports    : clk         in   1           system clock (posedge)
//            rst         in   1           asynchronous active-low reset
//            req_valid   in   1           load request present
//            req_ready   out  1           unit can accept a request
//            req_addr    in   ADDR_WIDTH  byte address
//            req_funct3  in   3           load funct3
//            mem_rd_en   out  1           one-cycle read strobe
//            mem_addr    out  ADDR_WIDTH  word-aligned read address
//            mem_rdata   in   DATA_WIDTH  read word
//            mem_rvalid  in   1           mem_rdata valid this cycle
//            rsp_valid   out  1           response present
//            rsp_ready   in   1           consumer accepts response
//            rsp_data    out  DATA_WIDTH  extended load result
//            rsp_err     out  1           response is an error (data is 0)
// Revision : 1.0 - initial release
// ============================================================================
module load_unit
  import load_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,   // only 32 is supported
  parameter int TIMEOUT    = 16    // WAIT cycles before a timeout, >= 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  load_state_t           state_q,     state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  // Only the byte lane of the address is needed after acceptance; the word
  // part lives in mem_addr_q.
  logic [1:0]            lane_q,      lane_d;
  logic [2:0]            funct3_q,    funct3_d;

  logic [DATA_WIDTH-1:0] ext_result;

  load_extend u_extend (
    .word   (mem_rdata),
    .lane   (lane_q),
    .funct3 (funct3_q),
    .result (ext_result)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_rd_en_d = mem_rd_en_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    funct3_d    = funct3_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          lane_d      = req_addr[1:0];
          funct3_d    = req_funct3;
          req_ready_d = 1'b0;
          if (is_illegal(req_funct3) || is_misaligned(req_funct3, req_addr[1:0])) begin
            // Rejected without touching memory.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            // Strobe and address are registered here so they appear
            // together with the ISSUE state.
            state_d     = ISSUE;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end

      ISSUE: begin
        mem_rd_en_d = 1'b0;
        cnt_d       = '0;
        state_d     = WAIT;
      end

      WAIT: begin
        // Data arriving in the final WAIT cycle still wins over the timeout.
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ext_result;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        // req_ready only rises with the IDLE state, so a request can never
        // be accepted in the handshake cycle.
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_rd_en_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      lane_q      <= '0;
      funct3_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      funct3_q    <= funct3_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule : load_unit
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_unit
// Purpose  : Self-checking bench for load_unit: table-driven loads with a
//            response scoreboard, plus hand sequences for reset, timeout,
//            backpressure and mid-transaction reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_unit;
  import load_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  load_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: a handshake completes on the posedge following a
  // negedge that sees valid && ready.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %h err %b expected no response", rsp_data, rsp_err);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk1("rsp_err", rsp_err, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{F3_LB,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{F3_LHU, 32'h0000_2002, 32'hBEEF_0001, 32'h0000_BEEF, 1'b0};
    vecs[2]  = '{F3_LH,  32'h0000_2002, 32'hBEEF_0001, 32'hFFFF_BEEF, 1'b0};
    vecs[3]  = '{F3_LW,  32'h0000_3001, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[4]  = '{3'b011, 32'h0000_3000, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[5]  = '{F3_LBU, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080, 1'b0};
    vecs[6]  = '{F3_LB,  32'h0000_1001, 32'h80FF_1234, 32'h0000_0012, 1'b0};
    vecs[7]  = '{F3_LW,  32'h0000_5000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{F3_LH,  32'h0000_2000, 32'h1234_8765, 32'hFFFF_8765, 1'b0};
    vecs[9]  = '{F3_LH,  32'h0000_2001, 32'h1234_8765, 32'h0000_0000, 1'b1};
    vecs[10] = '{3'b110, 32'h0000_2000, 32'h1234_8765, 32'h0000_0000, 1'b1};
    vecs[11] = '{3'b111, 32'h0000_2000, 32'h1234_8765, 32'h0000_0000, 1'b1};
    vecs[12] = '{F3_LBU, 32'h0000_7002, 32'h00AB_0000, 32'h0000_00AB, 1'b0};
    vecs[13] = '{F3_LB,  32'hFFFF_FFFC, 32'hAA55_AA7F, 32'h0000_007F, 1'b0};

    // ---------------- reset held with a request pending ----------------
    rst        = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_1003;
    req_funct3 = F3_LB;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_mem_rd_en", mem_rd_en, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
    end
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    rst = 1'b1;

    // ---------------- table-driven loads ----------------
    // The first vector is accepted on the first posedge after reset release.
    for (int i = 0; i < 14; i++) begin
      chk1("idle_req_ready", req_ready, 1'b1);
      req_valid  = 1'b1;
      req_addr   = vecs[i].addr;
      req_funct3 = vecs[i].f3;
      sb.push_back({vecs[i].exp_data, vecs[i].exp_err});
      step();                                   // cycle N+1
      req_valid = 1'b0;
      chk1("busy_req_ready", req_ready, 1'b0);
      if (!vecs[i].exp_err) begin
        chk1("issue_rd_en", mem_rd_en, 1'b1);
        chk("issue_mem_addr", mem_addr, {vecs[i].addr[31:2], 2'b00});
        step();                                 // cycle N+2 (WAIT)
        chk1("wait_rd_en", mem_rd_en, 1'b0);
        chk1("wait_rsp_valid", rsp_valid, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = vecs[i].rdata;
        step();                                 // cycle N+3 (RESP)
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        chk1("resp_valid_n3", rsp_valid, 1'b1);
      end else begin
        chk1("err_no_rd_en", mem_rd_en, 1'b0);
        chk1("err_valid_n1", rsp_valid, 1'b1);
      end
      step();                                   // handshake done
      chk1("post_hs_rsp_valid", rsp_valid, 1'b0);
    end

    // ---------------- timeout with late rvalid ----------------
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_4000;
    req_funct3 = F3_LW;
    sb.push_back({32'h0, 1'b1});
    step();                                     // N+1 ISSUE
    req_valid = 1'b0;
    chk1("to_issue_rd_en", mem_rd_en, 1'b1);
    repeat (TO) step();                         // last WAIT cycle
    chk1("to_not_early", rsp_valid, 1'b0);
    step();                                     // RESP
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_err", rsp_err, 1'b1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    step();
    step();
    mem_rvalid = 1'b0;
    chk("to_late_rvalid_data", rsp_data, 32'h0);
    chk1("to_late_rvalid_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    step();

    // ---------------- backpressure then mid-WAIT reset ----------------
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_5000;
    req_funct3 = F3_LW;
    sb.push_back({32'hCAFE_F00D, 1'b0});
    step();                                     // N+1 ISSUE
    req_addr = 32'h0000_6000;                   // next request stays pending
    step();                                     // N+2 WAIT
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    step();                                     // N+3 RESP
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_data", rsp_data, 32'hCAFE_F00D);
      chk1("bp_req_ready", req_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    step();                                     // handshake, back in IDLE
    chk1("hs_no_accept_ready", req_ready, 1'b1);
    chk1("hs_no_accept_rd_en", mem_rd_en, 1'b0);
    step();                                     // pending request accepted
    req_valid = 1'b0;
    chk1("rst2_issue_rd_en", mem_rd_en, 1'b1);
    chk("rst2_issue_addr", mem_addr, 32'h0000_6000);
    step();                                     // WAIT
    rst = 1'b0;
    #1;
    chk1("async_rst_req_ready", req_ready, 1'b1);
    chk1("async_rst_rd_en", mem_rd_en, 1'b0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk1("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk("async_rst_rsp_data", rsp_data, 32'h0);
    chk1("async_rst_rsp_err", rsp_err, 1'b0);
    step();
    step();
    rst        = 1'b1;
    mem_rvalid = 1'b1;                          // late data from the abandoned read
    mem_rdata  = 32'h5555_AAAA;
    step();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
      chk1("post_rst_req_ready", req_ready, 1'b1);
      step();
    end

    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_load_unit
`default_nettype wire
